// File: rtl/bcd_encoder_8bit.sv
// Three-digit BCD (0-399) to 8-bit binary converter using reverse double dabble.
// One conversion at a time: capture, digit check, eight shift cycles, completion pulse.
module bcd_encoder_8bit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [1:0] hundreds,
    output logic [7:0] binary,
    output logic       busy,
    output logic       done,
    output logic       err_digit,
    output logic       ovf,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  h_q;
    logic [3:0]  t_q;
    logic [3:0]  o_q;
    logic [7:0]  b_q;
    logic [2:0]  cnt_q;
    logic [7:0]  binary_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        ovf_q;

    logic [17:0] shifted;
    logic [1:0]  h_d;
    logic [3:0]  t_d;
    logic [3:0]  o_d;
    logic [7:0]  b_d;

    // Halving a BCD digit that received a carry-in of 8 must become 5, hence the -3.
    always_comb begin
        shifted = {h_q, t_q, o_q, b_q} >> 1;
        h_d     = shifted[17:16];
        t_d     = shifted[15:12];
        o_d     = shifted[11:8];
        b_d     = shifted[7:0];
        if (t_d >= 4'd8) t_d = t_d - 4'd3;
        if (o_d >= 4'd8) o_d = o_d - 4'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            h_q      <= 2'd0;
            t_q      <= 4'd0;
            o_q      <= 4'd0;
            b_q      <= 8'd0;
            cnt_q    <= 3'd0;
            binary_q <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        h_q     <= hundreds;
                        t_q     <= tens;
                        o_q     <= ones;
                        b_q     <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if ((t_q > 4'd9) || (o_q > 4'd9)) begin
                        err_q    <= 1'b1;
                        ovf_q    <= 1'b0;
                        binary_q <= 8'd0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q   <= 3'd0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    h_q   <= h_d;
                    t_q   <= t_d;
                    o_q   <= o_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        // Whatever remains in the BCD digits is value / 256.
                        binary_q <= b_d;
                        ovf_q    <= |{h_d, t_d, o_d};
                        err_q    <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign binary    = binary_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_digit = err_q;
    assign ovf       = ovf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_bcd_encoder_8bit.sv
// Self-checking bench for bcd_encoder_8bit: directed corner cases, random conversions,
// start-while-busy, continuous start, and asynchronous reset mid-conversion.
module tb_bcd_encoder_8bit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] hundreds;
  logic [7:0] binary;
  logic       busy;
  logic       done;
  logic       err_digit;
  logic       ovf;
  logic [1:0] state_o;

  int n_cmp;
  int n_err;
  logic [9:0] exp_q[$];

  bcd_encoder_8bit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .binary    (binary),
    .busy      (busy),
    .done      (done),
    .err_digit (err_digit),
    .ovf       (ovf),
    .state_o   (state_o)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // reference model: plain decimal arithmetic; result packed as {err, ovf, binary}
  function automatic logic [9:0] model(input int h, input int t, input int o);
    int v;
    logic [9:0] r;
    v = h * 100 + t * 10 + o;
    if (t > 9 || o > 9) r = {1'b1, 1'b0, 8'h00};
    else r = {1'b0, (v > 255), 8'(v % 256)};
    return r;
  endfunction

  function automatic int model_lat(input int t, input int o);
    return (t > 9 || o > 9) ? 2 : 10;
  endfunction

  // driver: one conversion, checked for latency, busy profile and result
  task automatic convert(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o);
    int lat;
    int got;
    logic busy_ok;
    logic [9:0] exp;
    exp_q.push_back(model(h, t, o));
    lat = model_lat(t, o);
    @(negedge clk);
    hundreds = h; tens = t; ones = o; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    hundreds = 2'($urandom); tens = 4'($urandom); ones = 4'($urandom);
    got = -1;
    busy_ok = 1'b1;
    for (int k = 0; k < 16 && got < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (done) got = k;
      else if (!busy) busy_ok = 1'b0;
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== lat) begin
      n_err++;
      $display("FAIL latency h=%0d t=%0d o=%0d: got %0d cycles, required %0d", h, t, o, got, lat);
    end
    n_cmp++;
    if (busy_ok !== 1'b1) begin
      n_err++;
      $display("FAIL busy_during h=%0d t=%0d o=%0d: busy dropped before done, required held high", h, t, o);
    end
    if (got >= 0) begin
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_at_done: got %b, required 0", busy);
      end
      n_cmp++;
      if ({err_digit, ovf, binary} !== exp) begin
        n_err++;
        $display("FAIL result h=%0d t=%0d o=%0d: got err=%b ovf=%b bin=%h, required err=%b ovf=%b bin=%h",
                 h, t, o, err_digit, ovf, binary, exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({binary, busy, done, err_digit, ovf} !== 12'h000) begin
      n_err++;
      $display("FAIL %s: got bin=%h busy=%b done=%b err=%b ovf=%b, required all zero",
               tag, binary, busy, done, err_digit, ovf);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; ones = 4'd0; tens = 4'd0; hundreds = 2'd0;
    #2 reset = 1'b1;
    #1 check_idle_outputs("reset_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_release");
  endtask

  task automatic test_directed();
    convert(2'd2, 4'd5, 4'd5);
    convert(2'd1, 4'd2, 4'd8);
    convert(2'd0, 4'd0, 4'd0);
    convert(2'd3, 4'd9, 4'd9);
    convert(2'd0, 4'd0, 4'hA);
    convert(2'd0, 4'hF, 4'd0);
    convert(2'd2, 4'd5, 4'd6);
    convert(2'd3, 4'hC, 4'hB);
  endtask

  task automatic test_random();
    logic [3:0] t;
    logic [3:0] o;
    for (int i = 0; i < 30; i++) begin
      t = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      o = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      convert(2'($urandom_range(0, 3)), t, o);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    int first;
    logic [9:0] exp;
    exp = model(1, 7, 3);
    @(negedge clk);
    hundreds = 2'd1; tens = 4'd7; ones = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    first = -1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) begin
        start = 1'b1; hundreds = 2'd3; tens = 4'd1; ones = 4'd1;
      end
      if (k == 5) start = 1'b0;
      if (done) begin
        dones++;
        if (first < 0) begin
          first = k;
          n_cmp++;
          if ({err_digit, ovf, binary} !== exp) begin
            n_err++;
            $display("FAIL start_ignored_result: got bin=%h ovf=%b err=%b, required bin=%h ovf=%b err=%b",
                     binary, ovf, err_digit, exp[7:0], exp[8], exp[9]);
          end
        end
      end
    end
    n_cmp++;
    if (dones !== 1 || first !== 10) begin
      n_err++;
      $display("FAIL start_ignored_count: got %0d done pulses (first at %0d), required 1 at 10", dones, first);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int last;
    int pulses;
    int h;
    int t;
    int o;
    logic [9:0] exp;
    @(negedge clk);
    h = $urandom_range(0, 3); t = $urandom_range(0, 9); o = $urandom_range(0, 9);
    hundreds = 2'(h); tens = 4'(t); ones = 4'(o);
    exp_q.push_back(model(h, t, o));
    start = 1'b1;
    cyc = 0; last = 0; pulses = 0;
    while (pulses < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if ((cyc - last) !== 11) begin
          n_err++;
          $display("FAIL b2b_spacing pulse %0d: got %0d cycles, required 11", pulses, cyc - last);
        end
        n_cmp++;
        if ({err_digit, ovf, binary} !== exp) begin
          n_err++;
          $display("FAIL b2b_result pulse %0d: got err=%b ovf=%b bin=%h, required err=%b ovf=%b bin=%h",
                   pulses, err_digit, ovf, binary, exp[9], exp[8], exp[7:0]);
        end
        last = cyc;
        pulses++;
        if (pulses < 4) begin
          h = $urandom_range(0, 3); t = $urandom_range(0, 9); o = $urandom_range(0, 9);
          hundreds = 2'(h); tens = 4'(t); ones = 4'(o);
          exp_q.push_back(model(h, t, o));
        end else begin
          start = 1'b0;
        end
      end
    end
    n_cmp++;
    if (pulses !== 4) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d done pulses, required 4", pulses);
    end
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL b2b_stop: got %0d extra done pulses after start released, required 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    convert(2'd2, 4'd5, 4'd5);
    @(negedge clk);
    hundreds = 2'd1; tens = 4'd2; ones = 4'd8; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_idle_outputs("reset_mid_async");
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL reset_mid_abort: got %0d cycles with done/busy after reset, required 0", dones);
    end
    convert(2'd0, 4'd4, 4'd2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
